// File: rtl/alu_4bit_if.sv
// ============================================================================
// Module   : alu_4bit_if
// Brief    : Operand/result bundle between the operand muxes and the ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_4bit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic             in_valid;
  logic [WIDTH-1:0] RES;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             out_valid;

  modport master (
    output A, B, sel, in_valid,
    input  RES, carry, zero, neg, out_valid
  );

  modport slave (
    input  A, B, sel, in_valid,
    output RES, carry, zero, neg, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/alu_4bit.sv
// ============================================================================
// Module   : alu_4bit
// Brief    : Registered ADD/NAND ALU with carry, zero and sign flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_4bit #(
  parameter int WIDTH = 4
) (
  input wire          clk,
  input wire          rst_n,
  alu_4bit_if.slave   bus
);

  localparam logic [WIDTH-1:0] c_ZERO   = '0;
  localparam logic             c_OP_ADD = 1'b0;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;
  logic             r_out_valid;

  always_comb begin
    w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    w_nand = ~(bus.A & bus.B);
    if (bus.sel == c_OP_ADD) begin
      w_res   = w_sum[WIDTH-1:0];
      w_carry = w_sum[WIDTH];
    end else begin
      w_res   = w_nand;
      w_carry = 1'b0;
    end
  end

  // Flags are held alongside RES so they always describe the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= c_ZERO;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        r_zero  <= (w_res == c_ZERO);
        r_neg   <= w_res[WIDTH-1];
      end
    end
  end

  assign bus.RES       = r_res;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_4bit.sv
// ============================================================================
// Module   : tb_alu_4bit
// Brief    : Self-checking bench for alu_4bit: directed table, corner
//            sequences and randomized ops against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_4bit;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       n;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  int   m_res;
  bit   m_c;
  bit   m_z;
  bit   m_n;

  vec_t vecs[6];

  alu_4bit_if #(.WIDTH(4)) bus ();

  alu_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input int res, input bit c, input bit z,
                         input bit n, input bit ov);
    chk({name, ".RES"},       {4'h0, bus.RES},   8'(res));
    chk({name, ".carry"},     {7'h0, bus.carry}, {7'h0, c});
    chk({name, ".zero"},      {7'h0, bus.zero},  {7'h0, z});
    chk({name, ".neg"},       {7'h0, bus.neg},   {7'h0, n});
    chk({name, ".out_valid"}, {7'h0, bus.out_valid}, {7'h0, ov});
  endtask

  // Reference: unsigned sum wraps mod 16; 4-bit NAND equals 15 - (a AND b).
  function automatic void model(input int a, input int b, input bit sel,
                                output int res, output bit c);
    int s;
    if (!sel) begin
      s   = a + b;
      res = s % 16;
      c   = (s >= 16);
    end else begin
      res = 15 - (a & b);
      c   = 1'b0;
    end
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic sel,
                       input logic v);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.sel      = sel;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    bit c;
    bit v;
    logic [3:0] ra, rb;
    logic       rs;

    vectors      = 0;
    miscompares  = 0;
    bus.A        = 4'h0;
    bus.B        = 4'h0;
    bus.sel      = 1'b0;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    vecs[0] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 4'b0100, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1};

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 chk_all("reset_async", 0, 0, 0, 0, 0);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    drive(4'h5, 4'h6, 1'b0, 1'b0);
    chk_all("reset_release_idle", 0, 0, 0, 0, 0);

    // Directed table, each followed by an idle cycle with different operands.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].res), vecs[i].c, vecs[i].z,
              vecs[i].n, 1'b1);
      drive(~vecs[i].a, vecs[i].b ^ 4'h5, ~vecs[i].sel, 1'b0);
      chk_all($sformatf("vec%0d_hold", i), int'(vecs[i].res), vecs[i].c, vecs[i].z,
              vecs[i].n, 1'b0);
    end

    // Back-to-back stream.
    drive(4'b0011, 4'b0100, 1'b0, 1'b1);
    chk_all("b2b_0", 4'b0111, 0, 0, 0, 1);
    drive(4'b0011, 4'b0100, 1'b1, 1'b1);
    chk_all("b2b_1", 4'b1111, 0, 0, 1, 1);
    drive(4'b0111, 4'b0111, 1'b0, 1'b1);
    chk_all("b2b_2", 4'b1110, 0, 0, 1, 1);

    // Reset mid-stream: clears at once and swallows the op at a reset edge.
    @(negedge clk);
    bus.A = 4'b1001; bus.B = 4'b1001; bus.sel = 1'b0; bus.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all("reset_mid_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("reset_mid_edge", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all("reset_mid_release", 0, 0, 0, 0, 0);

    // Randomized ops against the model; expected state held across idles.
    m_res = 0; m_c = 0; m_z = 0; m_n = 0;
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rs, v);
      if (v) begin
        model(int'(ra), int'(rb), rs, r, c);
        m_res = r;
        m_c   = c;
        m_z   = (r == 0);
        m_n   = (r >= 8);
      end
      chk_all($sformatf("rand%0d", i), m_res, m_c, m_z, m_n, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_4bit.md
Name: alu_4bit

Overview:
- Registered two-function ALU for the 4-bit CPU datapath, between the register file/operand muxes and the writeback path.
- Computes A+B (sel=0) or A NAND B (sel=1) on 4-bit operands.
- Result and flags are captured on the rising clock edge, giving one cycle of latency.
- Asynchronous active-low reset clears all outputs.

Parameters:
- WIDTH, 4, operand/result width in bits. The CPU uses only 4; other values need not be verified.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sel  input  1  function select: 0 = ADD, 1 = NAND.
- in_valid  input  1  operands/sel valid this cycle; capture enable.
- RES  output  WIDTH  registered result.
- carry  output  1  registered carry-out of ADD; 0 after NAND.
- zero  output  1  registered flag, 1 when captured RES == 0.
- neg  output  1  registered copy of RES[WIDTH-1] (two's-complement sign).
- out_valid  output  1  high for exactly the cycle after an accepted in_valid.

Behaviour:
- Reset: while rst_n=0, asynchronously force RES=0, carry=0, zero=0, neg=0, out_valid=0, independent of clk. Leaving reset takes effect on the next rising edge with rst_n=1.
- Combinational function:
  - sel=0: {c,r} = A + B, a WIDTH+1-bit unsigned sum. r is the low WIDTH bits, so the sum wraps mod 2^WIDTH; c is bit WIDTH.
  - sel=1: r = ~(A & B) bitwise; c = 0.
  - No subtract, no carry-in, no signed overflow flag.
- Capture, on each rising clk edge with rst_n=1:
  - in_valid=1: RES<=r, carry<=c, zero<=(r==0), neg<=r[WIDTH-1], out_valid<=1.
  - in_valid=0: RES, carry, zero and neg hold their previous values; out_valid<=0.
- Latency: exactly 1 clock from an accepted operand to valid RES. Throughput is one operation per clock; back-to-back in_valid is allowed.
- No backpressure; out_valid is informational and the consumer must sample it in that cycle.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- A or B changing while in_valid=0 has no effect on outputs.
- Reset asserted mid-stream discards any operation being captured that edge.
- Flags always describe the last captured result, including after NAND: zero=1 when A=B=all ones.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges -> RES=0000, carry=0, zero=0, neg=0, out_valid=0 immediately. Release, no in_valid -> all outputs stay 0.
- ADD: A=0011, B=0100, sel=0, in_valid=1 for one edge -> next cycle RES=0111, carry=0, zero=0, neg=0, out_valid=1. The following cycle out_valid=0 and RES holds 0111.
- NAND: A=0011, B=0100, sel=1 -> RES=1111 (-1), carry=0, zero=0, neg=1.
- ADD wrap: A=1111, B=0001, sel=0 -> RES=0000, carry=1, zero=1. Then A=1000, B=1000 -> RES=0000, carry=1, zero=1.
- NAND all ones: A=1111, B=1111, sel=1 -> RES=0000, zero=1, carry=0.
- Back-to-back: stream ADD(0011,0100), NAND(0011,0100), ADD(0111,0111) on consecutive edges -> RES 0111, 1111, 1110 (carry=0) on consecutive cycles with out_valid continuously 1.
- Reset mid-stream: assert rst_n mid-stream -> all outputs clear in the same cycle.
